// File: rtl/bram_stream_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bram_stream_fifo
//
// First-word-fall-through valid/ready FIFO. Storage is a 1R/1W block RAM with a
// registered read port. A small output stage sits behind the RAM: the RAM
// output register, a skid register and the output register. The stage is
// prefetched so that a consumer can pop every cycle, even straight after a
// stall, without bubbles. Every accepted word is counted in `count`, whether it
// is in the RAM, in flight on the read port or in the output stage.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     producer has a word on in_data
//   in_ready     FIFO accepts a word this cycle (count < DEPTH, out of reset)
//   in_data      write data
//   out_valid    out_data holds the oldest entry
//   out_ready    consumer takes out_data this cycle
//   out_data     registered read data
//   count        entries accepted and not yet popped
//   almost_full  registered flag, count >= ALMOST_FULL
// -----------------------------------------------------------------------------
module bram_stream_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             run_q;

  // Output stage: RAM read register (rd_*), skid register and output register.
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic       push;
  logic       pop;
  logic [1:0] stage_occ;
  logic       stage_full;
  logic       rd_en;
  logic       rd_take;

  assign in_ready  = run_q && (count_q < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid_q && out_ready;

  assign stage_occ  = 2'(out_valid_q) + 2'(skid_valid) + 2'(rd_valid);
  assign stage_full = out_valid_q && skid_valid;

  // Words still in the RAM = count minus words already in the stage. A read is
  // issued only if the returning word has a home without relying on a pop:
  // either the read register is empty, or its current word can move into the
  // skid/output pair. Because the RAM is never full while a push is accepted,
  // a read with RAM words pending never targets the address being written.
  assign rd_en   = (count_q > CW'(stage_occ)) && (!rd_valid || !stage_full);
  assign rd_take = rd_valid && (!stage_full || pop);

  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is inferred.
  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CW'(1);
    end
  end

  // NOTE: the RAM array and its read register have no reset so they map onto
  // block RAM; their contents are meaningless until the valid flags say so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      count_q     <= count_next;
      almost_full <= (count_next >= CW'(ALMOST_FULL));
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr   <= rd_ptr + AW'(1);
        rd_valid <= 1'b1;
      end else if (rd_take) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Skid/output pair behaves as a two-entry FIFO: out is the head, skid the
  // tail. The skid register is only ever valid while the output is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        out_data_q <= skid_data;
        if (rd_take) begin
          skid_data <= rd_data;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (rd_take) begin
        out_data_q <= rd_data;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (!out_valid_q) begin
      if (rd_take) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_data;
      end
    end else if (!skid_valid) begin
      if (rd_take) begin
        skid_valid <= 1'b1;
        skid_data  <= rd_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule
